// File: rtl/serial_1011_framer_if.sv
// Upstream payload handshake for serial_1011_framer.
//   data_in    : payload word, sampled on the accept edge
//   data_valid : upstream has a word to send
//   data_ready : framer can accept a word (registered in the framer)
// An accept happens on a rising clock edge where data_valid && data_ready.
// master = upstream source, slave = framer.
interface serial_1011_framer_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_in,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/serial_1011_framer.sv
// serial_1011_framer
// Transmit-side partner of the serial 1011 pattern detector. Accepts a
// parallel payload word over a valid/ready handshake and sends it on a
// single bit line as: SYNC marker (MSB first), payload (MSB first), then
// GAP_LEN idle cycles before the next word may be accepted.
// Ports:
//   clk          : rising-edge clock
//   rst          : asynchronous, active-high reset
//   up           : payload handshake (data_in, data_valid, data_ready)
//   d_out        : serial line, registered
//   frame_active : high while SYNC or payload bits are on d_out
//   sync_active  : high while SYNC bits are on d_out
//   done         : one-cycle pulse together with the last payload bit
module serial_1011_framer #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC     = 4'b1011,
    parameter int unsigned       GAP_LEN  = 2,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_1011_framer_if.slave  up,
    output logic                 d_out,
    output logic                 frame_active,
    output logic                 sync_active,
    output logic                 done
);

    localparam int unsigned FRAME_W  = SYNC_W + DATA_W;
    localparam int unsigned MAX_SD   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
    localparam int unsigned MAX_LEN  = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DATA_PEN  = CNT_W'((DATA_W >= 2) ? DATA_W - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN >= 1) ? GAP_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_GAP
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic               d_out_nxt;
    logic               ready_nxt;
    logic               frame_nxt;
    logic               sync_nxt;
    logic               done_nxt;
    logic               accept;

    assign accept = up.data_ready && up.data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            d_out        <= IDLE_BIT;
            up.data_ready <= 1'b0;
            frame_active <= 1'b0;
            sync_active  <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            shreg        <= shreg_nxt;
            d_out        <= d_out_nxt;
            up.data_ready <= ready_nxt;
            frame_active <= frame_nxt;
            sync_active  <= sync_nxt;
            done         <= done_nxt;
        end
    end

    // Marker and payload share one shift register: on accept the whole
    // frame {SYNC, data_in} is loaded already shifted by one, because its
    // first bit goes straight onto d_out. Every SYNC/DATA cycle then just
    // moves the register MSB onto the line.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        d_out_nxt = d_out;
        ready_nxt = up.data_ready;
        frame_nxt = frame_active;
        sync_nxt  = sync_active;
        done_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                d_out_nxt = IDLE_BIT;
                frame_nxt = 1'b0;
                sync_nxt  = 1'b0;
                if (accept) begin
                    state_nxt = S_SYNC;
                    cnt_nxt   = '0;
                    shreg_nxt = {SYNC, up.data_in} << 1;
                    d_out_nxt = SYNC[SYNC_W-1];
                    sync_nxt  = 1'b1;
                    frame_nxt = 1'b1;
                    ready_nxt = 1'b0;
                end else begin
                    // Also raises ready on the first edge after reset.
                    ready_nxt = 1'b1;
                end
            end

            S_SYNC: begin
                d_out_nxt = shreg[FRAME_W-1];
                shreg_nxt = shreg << 1;
                if (cnt == SYNC_LAST) begin
                    state_nxt = S_DATA;
                    cnt_nxt   = '0;
                    sync_nxt  = 1'b0;
                    // A one-bit payload makes its only bit the last one.
                    done_nxt  = (DATA_W == 1);
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == DATA_LAST) begin
                    d_out_nxt = IDLE_BIT;
                    frame_nxt = 1'b0;
                    cnt_nxt   = '0;
                    if (GAP_LEN == 0) begin
                        state_nxt = S_IDLE;
                        ready_nxt = 1'b1;
                    end else begin
                        state_nxt = S_GAP;
                    end
                end else begin
                    d_out_nxt = shreg[FRAME_W-1];
                    shreg_nxt = shreg << 1;
                    cnt_nxt   = cnt + 1'b1;
                    // done is registered, so it is raised on the edge that
                    // puts the LSB on the line.
                    done_nxt  = (cnt == DATA_PEN);
                end
            end

            S_GAP: begin
                d_out_nxt = IDLE_BIT;
                if (cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                d_out_nxt = IDLE_BIT;
                frame_nxt = 1'b0;
                sync_nxt  = 1'b0;
                ready_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_1011_framer.sv
// Testbench for serial_1011_framer: a default instance (8-bit payload,
// 1011 marker, 2-cycle gap) and a GAP_LEN=0 / 1101 / 4-bit instance.
// Drivers push hand-written expected frames into per-instance queues on
// each accept; monitors pop and compare every cycle the frame is active.
module tb_serial_1011_framer;

    typedef struct packed {
        logic d;
        logic s;
        logic dn;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   failed;
    int   det_cnt;
    logic [3:0] hist;

    logic d1, f1, s1, dn1;
    logic d2, f2, s2, dn2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;

    serial_1011_framer_if #(.DATA_W(8)) bus1 ();
    serial_1011_framer_if #(.DATA_W(4)) bus2 ();

    serial_1011_framer #(
        .DATA_W(8), .SYNC_W(4), .SYNC(4'b1011), .GAP_LEN(2), .IDLE_BIT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .up(bus1.slave),
        .d_out(d1), .frame_active(f1), .sync_active(s1), .done(dn1)
    );

    serial_1011_framer #(
        .DATA_W(4), .SYNC_W(4), .SYNC(4'b1101), .GAP_LEN(0), .IDLE_BIT(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .up(bus2.slave),
        .d_out(d2), .frame_active(f2), .sync_active(s2), .done(dn2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference 1011 detector listening to the default instance's line.
    initial begin
        hist = 4'b0000;
        det_cnt = 0;
    end
    always @(negedge clk) begin
        hist = {hist[2:0], d1};
        if (hist == 4'b1011) det_cnt++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (f1) begin
                chk("d1_queue_has_bit", q1.size() != 0, 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("d1_bit{d,sync,done}", {d1, s1, dn1}, e1);
                end
            end else begin
                chk("d1_idle{d,sync,done}", {d1, s1, dn1}, 3'b000);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (f2) begin
                chk("d2_queue_has_bit", q2.size() != 0, 1);
                if (q2.size() != 0) begin
                    e2 = q2.pop_front();
                    chk("d2_bit{d,sync,done}", {d2, s2, dn2}, e2);
                end
            end else begin
                chk("d2_idle{d,sync,done}", {d2, s2, dn2}, 3'b000);
            end
        end
    end

    task automatic push1(input logic [11:0] bits);
        for (int i = 0; i < 12; i++) begin
            q1.push_back('{d: bits[11-i], s: (i < 4), dn: (i == 11)});
        end
    endtask

    task automatic push2(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            q2.push_back('{d: bits[7-i], s: (i < 4), dn: (i == 7)});
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves data_valid high; returns the cycle number of the accept edge.
    task automatic send1(input logic [7:0] w, input logic [11:0] bits, output int acc);
        int n;
        n = 0;
        bus1.data_in = w;
        bus1.data_valid = 1'b1;
        @(negedge clk);
        while (!bus1.data_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send1_ready_within_bound", n < 50, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        push1(bits);
    endtask

    task automatic send2(input logic [3:0] w, input logic [7:0] bits, output int acc);
        int n;
        n = 0;
        bus2.data_in = w;
        bus2.data_valid = 1'b1;
        @(negedge clk);
        while (!bus2.data_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("send2_ready_within_bound", n < 50, 1);
        @(posedge clk);
        #1;
        acc = cyc;
        push2(bits);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, base;
        tests = 0;
        failed = 0;
        rst = 1'b0;
        bus1.data_in = '0;
        bus1.data_valid = 1'b0;
        bus2.data_in = '0;
        bus2.data_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_d_out", d1, 0);
        chk("reset_ready", bus1.data_ready, 0);
        chk("reset_frame_active", f1, 0);
        chk("reset_sync_active", s1, 0);
        chk("reset_done", dn1, 0);
        chk("reset_ready_dut2", bus2.data_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ready_low_before_first_edge", bus1.data_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_high_after_first_edge", bus1.data_ready, 1);

        // Single A5 frame, valid for one cycle.
        send1(8'hA5, 12'b1011_1010_0101, a);
        bus1.data_valid = 1'b0;
        wait_cyc(a + 13);
        chk("a5_ready_low_in_gap", bus1.data_ready, 0);
        wait_cyc(a + 14);
        chk("a5_ready_back_after_gap", bus1.data_ready, 1);
        chk("a5_queue_drained", q1.size(), 0);

        // Back-to-back with valid held high.
        send1(8'hFF, 12'b1011_1111_1111, a);
        send1(8'h00, 12'b1011_0000_0000, b);
        bus1.data_valid = 1'b0;
        chk("b2b_accept_spacing", b - a, 15);
        wait_cyc(b + 15);
        chk("b2b_queue_drained", q1.size(), 0);

        // Valid pulse while busy must be ignored.
        send1(8'hA5, 12'b1011_1010_0101, a);
        bus1.data_valid = 1'b0;
        wait_cyc(a + 3);
        bus1.data_in = 8'h3C;
        bus1.data_valid = 1'b1;
        @(negedge clk);
        chk("busy_ready_low", bus1.data_ready, 0);
        @(posedge clk);
        #1;
        bus1.data_valid = 1'b0;
        bus1.data_in = 8'h00;
        wait_cyc(a + 17);
        chk("busy_queue_drained", q1.size(), 0);
        chk("busy_no_extra_frame", f1, 0);

        // Asynchronous reset during payload bit 5.
        send1(8'hA5, 12'b1011_1010_0101, a);
        bus1.data_valid = 1'b0;
        wait_cyc(a + 8);
        chk("pre_reset_frame_active", f1, 1);
        #1 rst = 1'b1;
        #1;
        chk("midreset_d_out", d1, 0);
        chk("midreset_frame_active", f1, 0);
        chk("midreset_ready", bus1.data_ready, 0);
        chk("midreset_done", dn1, 0);
        q1.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("post_reset_ready_low", bus1.data_ready, 0);
        @(posedge clk);
        #1;
        chk("post_reset_ready_high", bus1.data_ready, 1);
        wait_cyc(cyc + 4);
        chk("post_reset_idle", f1, 0);

        // Loopback: one marker detection per all-zero frame.
        base = det_cnt;
        for (int k = 1; k <= 3; k++) begin
            send1(8'h00, 12'b1011_0000_0000, a);
            bus1.data_valid = 1'b0;
            wait_cyc(a + 15 + k);
            chk("loopback_detect_count", det_cnt - base, k);
        end
        chk("loopback_queue_drained", q1.size(), 0);

        // GAP_LEN=0, SYNC=1101, 4-bit payload.
        send2(4'h9, 8'b1101_1001, a);
        send2(4'h6, 8'b1101_0110, b);
        bus2.data_valid = 1'b0;
        chk("gap0_accept_spacing", b - a, 9);
        wait_cyc(b + 10);
        chk("gap0_queue_drained", q2.size(), 0);
        chk("gap0_ready_idle", bus2.data_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
